// File: rtl/input_conditioner_if.sv
// Raw PIO inputs and conditioned SoC-facing outputs of the input conditioner.
// master drives the raw buttons/switches and observes the clean levels;
// slave is the conditioner itself.
interface input_conditioner_if #(
  parameter int SW_WIDTH = 8
);
  logic                key_accumulate_n;
  logic                key_reset_n;
  logic [SW_WIDTH-1:0] sw_raw;
  logic                accumulate_export;
  logic                accumulate_pulse;
  logic                reset_1_export;
  logic [SW_WIDTH-1:0] switch_export;

  modport master (
    output key_accumulate_n,
    output key_reset_n,
    output sw_raw,
    input  accumulate_export,
    input  accumulate_pulse,
    input  reset_1_export,
    input  switch_export
  );

  modport slave (
    input  key_accumulate_n,
    input  key_reset_n,
    input  sw_raw,
    output accumulate_export,
    output accumulate_pulse,
    output reset_1_export,
    output switch_export
  );
endinterface

// File: rtl/input_conditioner.sv
// Front end for the SoC PIO inputs: two-flop synchronizers, a debounce FSM
// per pushbutton (active-low KEY in, active-high level out) and a shared
// stability counter for the slide-switch word. The accumulate key also
// produces a one-cycle strobe when a press is accepted.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19,
  parameter int SW_WIDTH        = 8
) (
  input logic                clk_clk,
  input logic                reset_reset_n,
  input_conditioner_if.slave io
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_PEND,
    PRESSED,
    RELEASE_PEND
  } key_state_t;

  // Saturating increment so the switch counter can never wrap.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= CNT_MAX) ? CNT_MAX : v + CNT_ONE;
  endfunction

  // bit 0 = accumulate key, bit 1 = reset key
  logic [1:0]          key_sync_p0;
  logic [1:0]          key_sync_p1;
  logic [1:0]          pressed;
  logic [1:0]          key_level;
  logic                acc_pulse_q;

  logic [SW_WIDTH-1:0] sw_sync_p0;
  logic [SW_WIDTH-1:0] sw_sync_p1;
  logic [SW_WIDTH-1:0] sw_prev_p2;
  logic [SW_WIDTH-1:0] sw_out_q;
  logic [CNT_W-1:0]    scnt_q;
  logic [CNT_W-1:0]    scnt_d;

  // Two-flop synchronizers; keys idle released (1), switches idle at 0.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      key_sync_p0 <= '1;
      key_sync_p1 <= '1;
      sw_sync_p0  <= '0;
      sw_sync_p1  <= '0;
    end else begin
      key_sync_p0 <= {io.key_reset_n, io.key_accumulate_n};
      key_sync_p1 <= key_sync_p0;
      sw_sync_p0  <= io.sw_raw;
      sw_sync_p1  <= sw_sync_p0;
    end
  end

  assign pressed = ~key_sync_p1;

  for (genvar k = 0; k < 2; k++) begin : g_key
    key_state_t       state_q;
    key_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;

    // Debounce next-state: a change is accepted only after an unbroken run of samples.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        RELEASED: begin
          if (pressed[k]) begin
            state_d = PRESS_PEND;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d = '0;
          end
        end
        PRESS_PEND: begin
          if (!pressed[k]) begin
            state_d = RELEASED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!pressed[k]) begin
            state_d = RELEASE_PEND;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d = '0;
          end
        end
        RELEASE_PEND: begin
          if (pressed[k]) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d = RELEASED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = RELEASED;
          cnt_d   = '0;
        end
      endcase
    end

    // State, counter and registered level (high while PRESSED or RELEASE_PEND).
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
        state_q <= RELEASED;
        cnt_q   <= '0;
        level_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        level_q <= (state_d == PRESSED) || (state_d == RELEASE_PEND);
      end
    end

    assign key_level[k] = level_q;

    if (k == 0) begin : g_pulse
      // Strobe only on the accepting PRESS_PEND -> PRESSED step, aligned with the level rise.
      always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
          acc_pulse_q <= 1'b0;
        end else begin
          acc_pulse_q <= (state_q == PRESS_PEND) && (state_d == PRESSED);
        end
      end
    end
  end

  // Any difference from the previous synced word restarts the stability count.
  always_comb begin
    scnt_d = sat_inc(scnt_q);
    if (sw_sync_p1 != sw_prev_p2) begin
      scnt_d = '0;
    end
  end

  // Previous word, stability counter, and whole-word update once stable.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sw_prev_p2 <= '0;
      scnt_q     <= '0;
      sw_out_q   <= '0;
    end else begin
      sw_prev_p2 <= sw_sync_p1;
      scnt_q     <= scnt_d;
      if (scnt_d == CNT_MAX) begin
        sw_out_q <= sw_sync_p1;
      end
    end
  end

  assign io.accumulate_export = key_level[0];
  assign io.reset_1_export    = key_level[1];
  assign io.accumulate_pulse  = acc_pulse_q;
  assign io.switch_export     = sw_out_q;

endmodule
